// File: rtl/tpu_job_scheduler.sv
// Job queue and launch sequencer between host control registers and the TPU core.
// Optional watchdog (ERR state, err/err_clr) is enabled with `define TPU_SCHED_TIMEOUT_EN.
module tpu_job_scheduler #(
  parameter int QDEPTH         = 4,
  parameter int CNT_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [7:0]                job_k,
  input  logic [7:0]                job_m,
  input  logic [7:0]                job_n,
  input  logic                      flush,
  output logic                      tpu_in_valid,
  output logic [7:0]                tpu_k,
  output logic [7:0]                tpu_m,
  output logic [7:0]                tpu_n,
  input  logic                      tpu_busy,
  input  logic                      tpu_ap_done,
  input  logic                      tpu_ap_idle,
  output logic                      done_pulse,
  output logic                      job_drop,
  output logic [CNT_BITS-1:0]       done_count,
  output logic [$clog2(QDEPTH):0]   q_level,
  output logic                      sched_busy,
  output logic                      err,
  input  logic                      err_clr
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_RETIRE
`ifdef TPU_SCHED_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [23:0]     mem_q [QDEPTH];
  logic [23:0]     mem_d [QDEPTH];
  logic            tpu_in_valid_q, tpu_in_valid_d;
  logic [23:0]     tpu_dims_q, tpu_dims_d;
  logic            done_pulse_q, done_pulse_d;
  logic            job_drop_q, job_drop_d;
  logic [CNT_BITS-1:0] done_count_q, done_count_d;
  logic            sched_busy_q, sched_busy_d;

  logic [PW-1:0]   level;
  logic            full, empty, handshake, dims_ok, push;

`ifdef TPU_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            unused_inputs;
  assign unused_inputs = tpu_busy;
  assign err = err_q;
`else
  logic            unused_inputs;
  assign unused_inputs = (^{tpu_busy, err_clr}) ^ (TIMEOUT_CYCLES == 0);
  assign err = 1'b0;
`endif

  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == PW'(QDEPTH));
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign job_ready = !full && !flush;
  assign handshake = job_valid && job_ready;
  assign dims_ok   = (job_k != 8'd0) && (job_m != 8'd0) && (job_n != 8'd0);
  assign push      = handshake && dims_ok;

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q + PW'(push);
    rd_ptr_d       = rd_ptr_q;
    mem_d          = mem_q;
    tpu_in_valid_d = 1'b0;
    tpu_dims_d     = tpu_dims_q;
    done_pulse_d   = 1'b0;
    job_drop_d     = handshake && !dims_ok;
    done_count_d   = done_count_q;
`ifdef TPU_SCHED_TIMEOUT_EN
    tmo_d          = tmo_q;
    err_d          = err_q && !err_clr;
`endif
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {job_k, job_m, job_n};
    end

    case (state_q)
      // Head is latched on the way into LAUNCH so the dims are valid alongside the strobe.
      S_IDLE: begin
        if (!empty && tpu_ap_idle && !flush) begin
          state_d        = S_LAUNCH;
          tpu_in_valid_d = 1'b1;
          tpu_dims_d     = mem_q[rd_ptr_q[AW-1:0]];
        end
      end
      S_LAUNCH: begin
        state_d = S_RUN;
        if (!empty) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
`ifdef TPU_SCHED_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      S_RUN: begin
        if (tpu_ap_done) begin
          state_d      = S_RETIRE;
          done_pulse_d = 1'b1;
        end
`ifdef TPU_SCHED_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      S_RETIRE: begin
        state_d      = S_IDLE;
        done_count_d = done_count_q + CNT_BITS'(1);
      end
`ifdef TPU_SCHED_TIMEOUT_EN
      S_ERR: begin
        err_d = 1'b1;
        if (err_clr) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end
    sched_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
      tpu_in_valid_q <= 1'b0;
      tpu_dims_q     <= '0;
      done_pulse_q   <= 1'b0;
      job_drop_q     <= 1'b0;
      done_count_q   <= '0;
      sched_busy_q   <= 1'b0;
`ifdef TPU_SCHED_TIMEOUT_EN
      tmo_q          <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      mem_q          <= mem_d;
      tpu_in_valid_q <= tpu_in_valid_d;
      tpu_dims_q     <= tpu_dims_d;
      done_pulse_q   <= done_pulse_d;
      job_drop_q     <= job_drop_d;
      done_count_q   <= done_count_d;
      sched_busy_q   <= sched_busy_d;
`ifdef TPU_SCHED_TIMEOUT_EN
      tmo_q          <= tmo_d;
      err_q          <= err_d;
`endif
    end
  end

  assign tpu_in_valid = tpu_in_valid_q;
  assign tpu_k        = tpu_dims_q[23:16];
  assign tpu_m        = tpu_dims_q[15:8];
  assign tpu_n        = tpu_dims_q[7:0];
  assign done_pulse   = done_pulse_q;
  assign job_drop     = job_drop_q;
  assign done_count   = done_count_q;
  assign q_level      = level;
  assign sched_busy   = sched_busy_q;

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Directed + randomized bench for tpu_job_scheduler against a queue-based job model.
module tb_tpu_job_scheduler;

  localparam int QDEPTH   = 4;
  localparam int CNT_BITS = 16;
  localparam int LW       = $clog2(QDEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                job_valid;
  logic                job_ready;
  logic [7:0]          job_k, job_m, job_n;
  logic                flush;
  logic                tpu_in_valid;
  logic [7:0]          tpu_k, tpu_m, tpu_n;
  logic                tpu_busy;
  logic                tpu_ap_done;
  logic                tpu_ap_idle;
  logic                done_pulse;
  logic                job_drop;
  logic [CNT_BITS-1:0] done_count;
  logic [LW-1:0]       q_level;
  logic                sched_busy;
  logic                err;
  logic                err_clr;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  int exp_count = 0;
  int exp_launches = 0;
  int launches_seen = 0;
  int w;

  always #5 clk = ~clk;

  // Independent tally of start strobes, compared against the model's launch count.
  always @(posedge clk) begin
    if (tpu_in_valid) launches_seen++;
  end

  tpu_job_scheduler #(.QDEPTH(QDEPTH), .CNT_BITS(CNT_BITS), .TIMEOUT_CYCLES(65535)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_k(job_k), .job_m(job_m), .job_n(job_n),
    .flush(flush),
    .tpu_in_valid(tpu_in_valid), .tpu_k(tpu_k), .tpu_m(tpu_m), .tpu_n(tpu_n),
    .tpu_busy(tpu_busy), .tpu_ap_done(tpu_ap_done), .tpu_ap_idle(tpu_ap_idle),
    .done_pulse(done_pulse), .job_drop(job_drop), .done_count(done_count),
    .q_level(q_level), .sched_busy(sched_busy),
    .err(err), .err_clr(err_clr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
    job_valid = v;
    job_k = k;
    job_m = m;
    job_n = n;
  endtask

  function automatic logic [7:0] rndDim(input bit allow_zero);
    if (allow_zero && ($urandom_range(0, 5) == 0)) return 8'd0;
    return 8'($urandom_range(1, 255));
  endfunction

  // Offer one job for one cycle; model accepts it if there is room and no dim is zero.
  task automatic pushJob(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
    bit exp_ready, zero;
    exp_ready = (exp_q.size() < QDEPTH);
    zero = (k == 8'd0) || (m == 8'd0) || (n == 8'd0);
    checkOutput("job_ready_offer", job_ready, exp_ready);
    applyStimulus(1'b1, k, m, n);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
    if (exp_ready && !zero) exp_q.push_back({k, m, n});
    checkOutput("job_drop", job_drop, exp_ready && zero);
  endtask

  task automatic waitLaunch(input int budget, output int waited);
    logic [23:0] exp_dims;
    waited = 0;
    while (!tpu_in_valid && waited < budget) begin
      tick();
      waited++;
    end
    if (!tpu_in_valid) begin
      checkOutput("launch_timeout", tpu_in_valid, 1);
    end else if (exp_q.size() == 0) begin
      checkOutput("unexpected_launch", tpu_in_valid, 0);
    end else begin
      exp_dims = exp_q.pop_front();
      exp_launches++;
      checkOutput("tpu_dims", {tpu_k, tpu_m, tpu_n}, exp_dims);
    end
  endtask

  task automatic retire(input int delay);
    for (int i = 0; i < delay; i++) tick();
    tpu_ap_done = 1'b1;
    tick();
    tpu_ap_done = 1'b0;
    exp_count++;
    checkOutput("done_pulse_hi", done_pulse, 1);
    tick();
    checkOutput("done_pulse_lo", done_pulse, 0);
    checkOutput("done_count", done_count, 32'(exp_count % (1 << CNT_BITS)));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_job_ready"}, job_ready, 1);
    checkOutput({tag, "_in_valid"}, tpu_in_valid, 0);
    checkOutput({tag, "_tpu_dims"}, {tpu_k, tpu_m, tpu_n}, 0);
    checkOutput({tag, "_done_pulse"}, done_pulse, 0);
    checkOutput({tag, "_job_drop"}, job_drop, 0);
    checkOutput({tag, "_done_count"}, done_count, 0);
    checkOutput({tag, "_q_level"}, q_level, 0);
    checkOutput({tag, "_sched_busy"}, sched_busy, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
    flush = 1'b0;
    tpu_busy = 1'b0;
    tpu_ap_done = 1'b0;
    tpu_ap_idle = 1'b1;
    err_clr = 1'b0;
    tick();
    tick();
    checkResetValues("reset");
    rst = 1'b0;
    tick();

    $display("[TB] single job 4x4x4");
    pushJob(8'd4, 8'd4, 8'd4);
    checkOutput("c1_q_level", q_level, 1);
    checkOutput("c1_sched_busy", sched_busy, 0);
    checkOutput("c1_in_valid", tpu_in_valid, 0);
    tick();
    checkOutput("c2_in_valid", tpu_in_valid, 1);
    waitLaunch(0, w);
    tick();
    checkOutput("c3_q_level", q_level, 0);
    checkOutput("c3_in_valid", tpu_in_valid, 0);
    checkOutput("c3_sched_busy", sched_busy, 1);
    retire(9);
    checkOutput("single_launches", launches_seen, exp_launches);

    $display("[TB] zero-dimension job");
    pushJob(8'd5, 8'd0, 8'd7);
    checkOutput("drop_q_level", q_level, 0);
    tick();
    checkOutput("drop_pulse_once", job_drop, 0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("drop_no_launch", launches_seen, exp_launches);

    $display("[TB] fill queue while TPU busy");
    pushJob(rndDim(0), rndDim(0), rndDim(0));
    tick();
    waitLaunch(4, w);
    tick();
    tpu_ap_idle = 1'b0;
    for (int i = 0; i < 4; i++) pushJob(rndDim(0), rndDim(0), rndDim(0));
    checkOutput("full_q_level", q_level, 4);
    checkOutput("full_job_ready", job_ready, 0);
    pushJob(rndDim(0), rndDim(0), rndDim(0));
    checkOutput("full_q_level_hold", q_level, 4);
    tpu_ap_idle = 1'b1;
    retire(1);
    waitLaunch(3, w);
    checkOutput("b2b_latency", w, 1);
    tick();
    checkOutput("after_pop_job_ready", job_ready, 1);
    checkOutput("after_pop_q_level", q_level, 3);
    retire($urandom_range(1, 8));
    for (int i = 0; i < 3; i++) begin
      waitLaunch(4, w);
      retire($urandom_range(1, 8));
    end
    checkOutput("fill_done_count", done_count, 6);
    checkOutput("fill_q_level", q_level, 0);
    checkOutput("fill_launches", launches_seen, exp_launches);

    $display("[TB] flush during run");
    pushJob(rndDim(0), rndDim(0), rndDim(0));
    tick();
    waitLaunch(4, w);
    tick();
    for (int i = 0; i < 3; i++) pushJob(rndDim(0), rndDim(0), rndDim(0));
    checkOutput("preflush_q_level", q_level, 3);
    flush = 1'b1;
    #1;
    checkOutput("flush_job_ready", job_ready, 0);
    tick();
    flush = 1'b0;
    exp_q.delete();
    checkOutput("flush_q_level", q_level, 0);
    retire(2);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("flush_no_launch", launches_seen, exp_launches);
    checkOutput("flush_idle", sched_busy, 0);

    $display("[TB] randomized bursts");
    for (int r = 0; r < 6; r++) begin
      tpu_ap_idle = 1'b0;
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
        pushJob(rndDim(1), rndDim(1), rndDim(1));
      end
      checkOutput("burst_q_level", q_level, exp_q.size());
      tpu_ap_done = 1'b1;
      tick();
      tpu_ap_done = 1'b0;
      tick();
      checkOutput("idle_ap_done_ignored", done_pulse, 0);
      tpu_ap_idle = 1'b1;
      while (exp_q.size() > 0) begin
        waitLaunch(4, w);
        retire($urandom_range(1, 12));
      end
      checkOutput("burst_launches", launches_seen, exp_launches);
    end

    $display("[TB] reset during run");
    pushJob(rndDim(0), rndDim(0), rndDim(0));
    tick();
    waitLaunch(4, w);
    tick();
    pushJob(rndDim(0), rndDim(0), rndDim(0));
    pushJob(rndDim(0), rndDim(0), rndDim(0));
    rst = 1'b1;
    #1;
    checkResetValues("midrun_reset");
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_count = 0;
    tick();
    tpu_ap_done = 1'b1;
    tick();
    tpu_ap_done = 1'b0;
    checkOutput("post_reset_done_pulse", done_pulse, 0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("post_reset_done_count", done_count, 0);
    checkOutput("post_reset_busy", sched_busy, 0);
    checkOutput("post_reset_launches", launches_seen, exp_launches);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
